// File: rtl/issue_scoreboard_if.sv
// Issue-stage bundle interface between decode and the hazard scoreboard.
// Carries both slot descriptors, the squash request and the scoreboard's hazard and status outputs.
interface issue_scoreboard_if #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned CW   = 16
);
    logic            flush;
    logic            issue_valid;

    logic            s1_we;
    logic            s1_ld;
    logic [AW-1:0]   s1_rd;
    logic [AW-1:0]   s1_rn;
    logic [AW-1:0]   s1_rm;
    logic            s1_rn_v;
    logic            s1_rm_v;

    logic            s2_we;
    logic            s2_ld;
    logic [AW-1:0]   s2_rd;
    logic [AW-1:0]   s2_rn;
    logic [AW-1:0]   s2_rm;
    logic            s2_rn_v;
    logic            s2_rm_v;

    logic            stall;
    logic            issue_fire;
    logic [NREG-1:0] busy_vec;
    logic            waw_err;
    logic [CW-1:0]   stall_cycles;

    // Decode side: presents bundles, observes hazards.
    modport master (
        output flush, issue_valid,
        output s1_we, s1_ld, s1_rd, s1_rn, s1_rm, s1_rn_v, s1_rm_v,
        output s2_we, s2_ld, s2_rd, s2_rn, s2_rm, s2_rn_v, s2_rm_v,
        input  stall, issue_fire, busy_vec, waw_err, stall_cycles
    );

    // Scoreboard side.
    modport slave (
        input  flush, issue_valid,
        input  s1_we, s1_ld, s1_rd, s1_rn, s1_rm, s1_rn_v, s1_rm_v,
        input  s2_we, s2_ld, s2_rd, s2_rn, s2_rm, s2_rn_v, s2_rm_v,
        output stall, issue_fire, busy_vec, waw_err, stall_cycles
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard for the 2-slot VLIW pipeline: tracks in-flight writes,
// stalls bundles on unforwardable (load-use) sources, and publishes the pending-write vector.
module issue_scoreboard #(
    parameter int unsigned NREG       = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned LD_STALL   = 1,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned CW         = 16
) (
    input  logic         clk,
    input  logic         rst,
    issue_scoreboard_if.slave sb
);
    localparam int unsigned RdyW  = 2;
    localparam int unsigned PendW = 3;

    logic [RdyW-1:0]  rdyCnt   [NREG];
    logic [RdyW-1:0]  rdyNext  [NREG];
    logic [PendW-1:0] pendCnt  [NREG];
    logic [PendW-1:0] pendNext [NREG];

    logic [NREG-1:0]  rdyBusy;
    logic [NREG-1:0]  busyVec;
    logic [NREG-1:0]  busyNext;
    logic             wawErr;
    logic             wawNext;
    logic [CW-1:0]    stallCnt;
    logic [CW-1:0]    stallNext;

    logic             stallC;
    logic             fireC;
    logic             s1Writes;
    logic             s2Writes;

    // Registers whose value cannot be forwarded yet; r0 is never blocked.
    always_comb begin
        rdyBusy = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            rdyBusy[r] = (rdyCnt[r] != '0);
        end
    end

    // Both slots check pre-bundle state only, so intra-bundle dependencies never stall.
    always_comb begin
        stallC = 1'b0;
        if (sb.issue_valid) begin
            stallC = (sb.s1_rn_v && rdyBusy[sb.s1_rn]) ||
                     (sb.s1_rm_v && rdyBusy[sb.s1_rm]) ||
                     (sb.s2_rn_v && rdyBusy[sb.s2_rn]) ||
                     (sb.s2_rm_v && rdyBusy[sb.s2_rm]);
        end
    end

    assign fireC    = sb.issue_valid && !stallC && !sb.flush;
    assign s1Writes = fireC && sb.s1_we && (sb.s1_rd != '0);
    assign s2Writes = fireC && sb.s2_we && (sb.s2_rd != '0);

    // Next tracking state: decrement, then slot 1 update, then slot 2 (wins on WAW), then squash.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            rdyNext[r]  = (rdyCnt[r]  != '0) ? rdyCnt[r]  - 1'b1 : '0;
            pendNext[r] = (pendCnt[r] != '0) ? pendCnt[r] - 1'b1 : '0;
        end

        if (s1Writes) begin
            rdyNext[sb.s1_rd]  = sb.s1_ld ? RdyW'(LD_STALL) : '0;
            pendNext[sb.s1_rd] = PendW'(PIPE_DEPTH);
        end
        if (s2Writes) begin
            rdyNext[sb.s2_rd]  = sb.s2_ld ? RdyW'(LD_STALL) : '0;
            pendNext[sb.s2_rd] = PendW'(PIPE_DEPTH);
        end

        if (sb.flush) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                rdyNext[r]  = '0;
                pendNext[r] = '0;
            end
        end

        rdyNext[0]  = '0;
        pendNext[0] = '0;

        busyNext = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            busyNext[r] = (pendNext[r] != '0);
        end
    end

    // WAW pulse and saturating stall counter; a squashed cycle is not a counted stall.
    always_comb begin
        wawNext   = s1Writes && s2Writes && (sb.s1_rd == sb.s2_rd);
        stallNext = stallCnt;
        if (sb.issue_valid && stallC && !sb.flush && (stallCnt != '1)) begin
            stallNext = stallCnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                rdyCnt[r]  <= '0;
                pendCnt[r] <= '0;
            end
            busyVec  <= '0;
            wawErr   <= 1'b0;
            stallCnt <= '0;
        end else begin
            rdyCnt   <= rdyNext;
            pendCnt  <= pendNext;
            busyVec  <= busyNext;
            wawErr   <= wawNext;
            stallCnt <= stallNext;
        end
    end

    assign sb.stall        = stallC;
    assign sb.issue_fire   = fireC;
    assign sb.busy_vec     = busyVec;
    assign sb.waw_err      = wawErr;
    assign sb.stall_cycles = stallCnt;

endmodule
